// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a TX FIFO and a programmable baud divisor.
// Register reads are combinational so a single-cycle core sees them during the load.
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RST    = 16'd434
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemWrite,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        sel,
  output logic        tx,
  output logic        busy
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  // IDLE: line high, waiting for FIFO | START/DATA/STOP: frame bits, each bit_div clocks
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t      state_q, state_d;
  logic [AW:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [7:0]  mem_q [FIFO_DEPTH];
  logic [7:0]  shift_q, shift_d;
  logic [15:0] bit_div_q, bit_div_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bitcnt_q, bitcnt_d;
  logic [15:0] div_q, div_d;
  logic        ovf_q, ovf_d;
  logic        tx_q, tx_d;

  logic [3:0]  off;
  logic        wr_en, push_req, push, pop, clr_ovf, set_ovf, div_wr;
  logic        empty, full, bit_end;
  logic [7:0]  head;
  logic        unused_wdata;

  assign sel      = (ALUResult[31:4] == BASE_ADDR[31:4]);
  assign off      = ALUResult[3:0];
  assign wr_en    = MemWrite & sel;
  assign push_req = wr_en & (off == 4'h0);
  assign clr_ovf  = wr_en & (off == 4'h4) & WriteData[3];
  assign div_wr   = wr_en & (off == 4'h8);
  assign unused_wdata = ^WriteData[31:16];

  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign head    = mem_q[rptr_q[AW-1:0]];
  assign bit_end = (cnt_q == bit_div_q - 16'd1);
  assign tx      = tx_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      wptr_q    <= '0;
      rptr_q    <= '0;
      shift_q   <= '0;
      bit_div_q <= DIV_RST;
      cnt_q     <= '0;
      bitcnt_q  <= '0;
      div_q     <= DIV_RST;
      ovf_q     <= 1'b0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      shift_q   <= shift_d;
      bit_div_q <= bit_div_d;
      cnt_q     <= cnt_d;
      bitcnt_q  <= bitcnt_d;
      div_q     <= div_d;
      ovf_q     <= ovf_d;
      tx_q      <= tx_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q[AW-1:0]] <= WriteData[7:0];
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bitcnt_d  = bitcnt_q;
    shift_d   = shift_q;
    bit_div_d = bit_div_q;
    unique case (state_q)
      S_IDLE: begin
        if (pop) begin
          shift_d   = head;
          bit_div_d = div_q;
          cnt_d     = '0;
          state_d   = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          cnt_d    = '0;
          bitcnt_d = '0;
          state_d  = S_DATA;
        end else cnt_d = cnt_q + 16'd1;
      end
      S_DATA: begin
        if (bit_end) begin
          cnt_d   = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bitcnt_q == 3'd7) state_d = S_STOP;
          else bitcnt_d = bitcnt_q + 3'd1;
        end else cnt_d = cnt_q + 16'd1;
      end
      S_STOP: begin
        if (bit_end) begin
          cnt_d = '0;
          // back-to-back frames: reload straight into START with no idle gap
          if (pop) begin
            shift_d   = head;
            bit_div_d = div_q;
            state_d   = S_START;
          end else state_d = S_IDLE;
        end else cnt_d = cnt_q + 16'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pop  = ~empty & ((state_q == S_IDLE) | ((state_q == S_STOP) & bit_end));
    busy = (state_q != S_IDLE) | ~empty;
    tx_d = 1'b1;
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_comb begin
    push    = push_req & (~full | pop);
    set_ovf = push_req & full & ~pop;
    ovf_d   = set_ovf | (ovf_q & ~clr_ovf);
    div_d   = div_q;
    if (div_wr) div_d = (WriteData[15:0] == 16'd0) ? 16'd1 : WriteData[15:0];
    wptr_d  = push ? wptr_q + PTR_ONE : wptr_q;
    rptr_d  = pop ? rptr_q + PTR_ONE : rptr_q;
  end

  always_comb begin
    ReadData = '0;
    if (sel) begin
      case (off)
        4'h4:    ReadData = {28'b0, ovf_q, busy, full, empty};
        4'h8:    ReadData = {16'b0, div_q};
        default: ReadData = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: a frame-level model (byte queue + per-frame bit timeline)
// checked every cycle, plus hand-computed waveform and register expectations.
module tb_mmio_uart_tx;

  localparam logic [31:0] BASE = 32'h1000_0000;
  localparam logic [31:0] TXD  = BASE;
  localparam logic [31:0] STA  = BASE + 32'h4;
  localparam logic [31:0] BAUD = BASE + 32'h8;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        MemWrite = 1'b0;
  logic [31:0] ALUResult = '0;
  logic [31:0] WriteData = '0;
  logic [31:0] ReadData;
  logic        sel, tx, busy;

  int checks = 0;
  int errors = 0;

  mmio_uart_tx #(.BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH), .DIV_RST(16'd434)) dut (
    .clk(clk), .rst(rst), .MemWrite(MemWrite), .ALUResult(ALUResult),
    .WriteData(WriteData), .ReadData(ReadData), .sel(sel), .tx(tx), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- frame-level model ----------------
  logic [7:0]  mq[$];
  bit          m_in_frame;
  logic [9:0]  m_bits;
  int          m_fdiv, m_pos;
  bit          m_ovf;
  logic [15:0] m_div;

  function automatic logic m_sel(input logic [31:0] a);
    return a[31:4] == BASE[31:4];
  endfunction

  function automatic logic m_busy();
    return m_in_frame || (mq.size() > 0);
  endfunction

  function automatic logic m_tx();
    return m_in_frame ? m_bits[m_pos / m_fdiv] : 1'b1;
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    if (!m_sel(a)) return 32'h0;
    case (a[3:0])
      4'h4:    return {28'b0, m_ovf, m_busy(), mq.size() == DEPTH, mq.size() == 0};
      4'h8:    return {16'b0, m_div};
      default: return 32'h0;
    endcase
  endfunction

  task automatic m_reset();
    mq.delete();
    m_in_frame = 0;
    m_bits = '1;
    m_pos = 0;
    m_fdiv = 1;
    m_ovf = 0;
    m_div = 16'd434;
  endtask

  task automatic m_step();
    logic       wr;
    logic [3:0] o;
    logic [7:0] b;
    wr = MemWrite && m_sel(ALUResult);
    o  = ALUResult[3:0];
    if (m_in_frame) begin
      if (m_pos == 10 * m_fdiv - 1) m_in_frame = 0;
      else m_pos++;
    end
    if (!m_in_frame && mq.size() > 0) begin
      b = mq.pop_front();
      m_bits = {1'b1, b, 1'b0};
      m_fdiv = int'(m_div);
      m_pos = 0;
      m_in_frame = 1;
    end
    if (wr && o == 4'h4 && WriteData[3]) m_ovf = 0;
    if (wr && o == 4'h0) begin
      if (mq.size() == DEPTH) m_ovf = 1;
      else mq.push_back(WriteData[7:0]);
    end
    if (wr && o == 4'h8) m_div = (WriteData[15:0] == 16'd0) ? 16'd1 : WriteData[15:0];
  endtask

  always @(negedge clk) begin
    if (!rst) m_reset();
    chk("tx", {31'b0, tx}, {31'b0, m_tx()});
    chk("busy", {31'b0, busy}, {31'b0, m_busy()});
    chk("sel", {31'b0, sel}, {31'b0, m_sel(ALUResult)});
    chk("rdata", ReadData, m_read(ALUResult));
    if (rst) m_step();
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
    MemWrite = 1'b1;
    ALUResult = a;
    WriteData = d;
    tick();
    MemWrite = 1'b0;
    WriteData = '0;
  endtask

  task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
    ALUResult = a;
    #1;
    chk(name, ReadData, exp);
  endtask

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    while (busy && n < limit) begin
      tick();
      n++;
    end
    chk("idle_timeout", {31'b0, busy}, 32'h0);
  endtask

  logic [9:0] pat;
  logic       samp [40];

  initial begin
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;

    // 1: reset values and register map holes
    rd_chk("t1_status", STA, 32'h1);
    rd_chk("t1_baud", BAUD, 32'd434);
    chk("t1_tx", {31'b0, tx}, 32'h1);
    ALUResult = STA;
    #1;
    chk("t1_sel", {31'b0, sel}, 32'h1);
    tick();
    rd_chk("t1_off_c", BASE + 32'hC, 32'h0);
    rd_chk("t1_unaligned", BASE + 32'h5, 32'h0);
    rd_chk("t1_txdata_rd", TXD, 32'h0);
    bus_wr(BASE + 32'hC, 32'hFFFF);
    rd_chk("t1_baud_after_c", BAUD, 32'd434);

    // 2: single frame 0xA5 at div 4
    tick();
    bus_wr(BAUD, 32'd4);
    bus_wr(TXD, 32'hA5);
    pat = 10'b11_0100_1010;
    for (int i = 0; i < 40; i++) begin
      tick();
      samp[i] = tx;
    end
    for (int i = 0; i < 40; i++) chk("t2_bit", {31'b0, samp[i]}, {31'b0, pat[i / 4]});
    chk("t2_busy_40", {31'b0, busy}, 32'h1);
    tick();
    chk("t2_busy_41", {31'b0, busy}, 32'h0);

    // 3: fill FIFO, overflow, clear, push concurrent with pop
    bus_wr(BAUD, 32'd1);
    for (int i = 0; i < 9; i++) bus_wr(TXD, 32'h30 + i);
    rd_chk("t3_full", STA, 32'h6);
    bus_wr(TXD, 32'h99);
    rd_chk("t3_ovf", STA, 32'hE);
    bus_wr(STA, 32'h8);
    rd_chk("t3_ovf_clr", STA, 32'h6);
    bus_wr(TXD, 32'h77);
    rd_chk("t3_push_pop", STA, 32'h6);
    wait_idle(300);

    // 4: contiguous frames 0x00 then 0xFF at div 2
    bus_wr(BAUD, 32'd2);
    bus_wr(TXD, 32'h00);
    bus_wr(TXD, 32'hFF);
    repeat (17) tick();
    chk("t4_e18", {31'b0, tx}, 32'h0);
    tick();
    chk("t4_e19", {31'b0, tx}, 32'h1);
    tick();
    chk("t4_e20", {31'b0, tx}, 32'h1);
    tick();
    chk("t4_e21", {31'b0, tx}, 32'h0);
    repeat (2) tick();
    chk("t4_e23", {31'b0, tx}, 32'h1);
    wait_idle(100);

    // 5: divisor change mid-frame applies to next frame only
    bus_wr(BAUD, 32'd4);
    bus_wr(TXD, 32'h5A);
    bus_wr(TXD, 32'h01);
    repeat (2) tick();
    bus_wr(BAUD, 32'd8);
    repeat (36) tick();
    chk("t5_e40", {31'b0, tx}, 32'h1);
    tick();
    chk("t5_e41", {31'b0, tx}, 32'h0);
    repeat (7) tick();
    chk("t5_e48", {31'b0, tx}, 32'h0);
    tick();
    chk("t5_e49", {31'b0, tx}, 32'h1);
    repeat (71) tick();
    chk("t5_busy_120", {31'b0, busy}, 32'h1);
    tick();
    chk("t5_busy_121", {31'b0, busy}, 32'h0);
    bus_wr(BAUD, 32'd0);
    rd_chk("t5_baud_zero", BAUD, 32'd1);

    // 6: async reset mid-DATA, then out-of-window access
    tick();
    bus_wr(BAUD, 32'd4);
    bus_wr(TXD, 32'h00);
    bus_wr(TXD, 32'h11);
    bus_wr(TXD, 32'h22);
    repeat (10) tick();
    chk("t6_data_low", {31'b0, tx}, 32'h0);
    #1;
    rst = 1'b0;
    #1;
    chk("t6_tx_async", {31'b0, tx}, 32'h1);
    chk("t6_busy_async", {31'b0, busy}, 32'h0);
    tick();
    rst = 1'b1;
    rd_chk("t6_status", STA, 32'h1);
    rd_chk("t6_baud", BAUD, 32'd434);
    ALUResult = 32'h2000_0000;
    #1;
    chk("t6_sel_out", {31'b0, sel}, 32'h0);
    chk("t6_rdata_out", ReadData, 32'h0);
    bus_wr(32'h2000_0000, 32'h55);
    repeat (3) tick();
    chk("t6_no_push_busy", {31'b0, busy}, 32'h0);
    chk("t6_no_push_tx", {31'b0, tx}, 32'h1);
    rd_chk("t6_status_end", STA, 32'h1);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
